// File: rtl/mdu_wb.sv
// Iterative unsigned multiply/divide unit: one result bit per clock, result
// delivered to the register-file write port through a request/grant handshake.
module mdu_wb #(
    parameter int W  = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [AW-1:0] dst,
    output logic          busy,
    output logic          we,
    output logic [AW-1:0] wad,
    output logic [W-1:0]  wd,
    input  logic          wb_gnt
);

    localparam int CW = $clog2(W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIVU = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [1:0]     opr;
    logic [AW-1:0]  dreg;
    logic [W-1:0]   opb;
    logic [2*W-1:0] prod;
    logic [W:0]     rem;
    logic [W-1:0]   quo;

    logic [W:0]     psum;
    logic [2*W-1:0] prod_nx;
    logic [W:0]     rsh;
    logic [W:0]     rdiff;
    logic [W-1:0]   qsh;
    logic [W:0]     rem_nx;
    logic [W-1:0]   quo_nx;
    logic [W-1:0]   res;

    // Multiply: the low half of prod starts as the multiplier and drains out
    // to the right as the partial product grows into the upper half.
    always_comb begin
        psum    = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opb} : {(W+1){1'b0}});
        prod_nx = {psum, prod[W-1:1]};
    end

    // Restoring division; rem carries one extra bit so the shifted-in value
    // can exceed W bits before the compare.
    always_comb begin
        rsh   = {rem[W-1:0], quo[W-1]};
        qsh   = {quo[W-2:0], 1'b0};
        rdiff = rsh - {1'b0, opb};
        if (rsh >= {1'b0, opb}) begin
            rem_nx = rdiff;
            quo_nx = {qsh[W-1:1], 1'b1};
        end else begin
            rem_nx = rsh;
            quo_nx = qsh;
        end
    end

    // Result is taken from the final iteration's next-state values so it can
    // be registered on the same edge that enters WB.
    always_comb begin
        res = '0;
        case (opr)
            OP_MUL:  res = prod_nx[W-1:0];
            OP_MULH: res = prod_nx[2*W-1:W];
            OP_DIVU: res = quo_nx;
            OP_REMU: res = rem_nx[W-1:0];
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            opr   <= '0;
            dreg  <= '0;
            opb   <= '0;
            prod  <= '0;
            rem   <= '0;
            quo   <= '0;
            wad   <= '0;
            wd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opr   <= op;
                        dreg  <= dst;
                        opb   <= b;
                        prod  <= {{W{1'b0}}, a};
                        rem   <= '0;
                        quo   <= a;
                        cnt   <= CW'(W - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (opr[1]) begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                    end else begin
                        prod <= prod_nx;
                    end
                    if (cnt == '0) begin
                        wd    <= res;
                        wad   <= dreg;
                        state <= WB;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WB: begin
                    if (wb_gnt)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign we   = (state == WB);

endmodule

// File: tb/tb_mdu_wb.sv
// Directed self-checking bench for mdu_wb: arithmetic results, writeback
// timing, grant stall, busy rejection and asynchronous reset abort.
module tb_mdu_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [1:0]  dst;
    logic        busy, we;
    logic [1:0]  wad;
    logic [15:0] wd;
    logic        wb_gnt;

    int nchk  = 0;
    int npass = 0;

    mdu_wb #(.W(16), .AW(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .dst(dst), .busy(busy), .we(we), .wad(wad), .wd(wd), .wb_gnt(wb_gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Full op with grant held high: we must rise 16 edges after E0 and last one cycle.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [1:0] d, input logic [15:0] exp);
        wb_gnt = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; dst = d;
        @(posedge clk); #1;
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; dst = ~d;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        repeat (15) @(posedge clk);
        #1;
        chk({tag, ".we_early"}, {31'd0, we}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ".we"}, {31'd0, we}, 32'd1);
        chk({tag, ".wad"}, {30'd0, wad}, {30'd0, d});
        chk({tag, ".wd"}, {16'd0, wd}, {16'd0, exp});
        @(posedge clk); #1;
        chk({tag, ".we_drop"}, {31'd0, we}, 32'd0);
        chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic saw_busy;
        logic saw_we;
        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; dst = '0; wb_gnt = 1'b0;
        #2;
        chk("reset", {13'd0, busy, we, wad, wd}, 32'd0);
        #10 rst = 1'b0;

        do_op("mul",   2'd0, 16'd300,  16'd500, 2'd3, 16'h49F0);
        do_op("mulh",  2'd1, 16'd300,  16'd500, 2'd3, 16'h0002);
        do_op("divu",  2'd2, 16'd1000, 16'd7,   2'd1, 16'h008E);
        do_op("remu",  2'd3, 16'd1000, 16'd7,   2'd2, 16'h0006);
        do_op("div0",  2'd2, 16'h1234, 16'd0,   2'd1, 16'hFFFF);
        do_op("rem0",  2'd3, 16'h1234, 16'd0,   2'd3, 16'h1234);

        // Grant stall: write triple held while the mux withholds the port.
        wb_gnt = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 16'd1000; b = 16'd7; dst = 2'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("stall.enter", {13'd0, busy, we, wad, wd}, {13'd0, 1'b1, 1'b1, 2'd2, 16'h008E});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall.hold", {13'd0, busy, we, wad, wd}, {13'd0, 1'b1, 1'b1, 2'd2, 16'h008E});
        end
        wb_gnt = 1'b1;
        @(posedge clk); #1;
        wb_gnt = 1'b0;
        chk("stall.release", {30'd0, busy, we}, 32'd0);

        // Busy rejection: starts during RUN, WB and on the grant edge are dropped.
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 16'd300; b = 16'd500; dst = 2'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 2 || k == 9) begin
                start = 1'b1; op = 2'd2; a = 16'd5; b = 16'd1; dst = 2'd2;
            end else begin
                start = 1'b0;
            end
        end
        chk("rej.wd", {14'd0, wad, wd}, {14'd0, 2'd1, 16'h49F0});
        start = 1'b1; op = 2'd3; a = 16'd9; b = 16'd2; dst = 2'd3;
        @(posedge clk); #1;
        chk("rej.wb_hold", {13'd0, busy, we, wad, wd}, {13'd0, 1'b1, 1'b1, 2'd1, 16'h49F0});
        wb_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wb_gnt = 1'b0;
        chk("rej.exit", {31'd0, busy}, 32'd0);
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy || we) saw_busy = 1'b1;
        end
        chk("rej.no_second", {31'd0, saw_busy}, 32'd0);
        do_op("accept", 2'd0, 16'd3, 16'd4, 2'd2, 16'h000C);

        // Asynchronous reset in the middle of RUN aborts with no write.
        wb_gnt = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 16'd300; b = 16'd500; dst = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst.async", {13'd0, busy, we, wad, wd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_we = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (we || busy) saw_we = 1'b1;
        end
        chk("rst.no_write", {31'd0, saw_we}, 32'd0);
        do_op("post_rst", 2'd0, 16'd3, 16'd4, 2'd1, 16'h000C);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
